// File: rtl/shift_rows_pipe.sv
// Registered Rijndael ShiftRows stage (NB columns, DEPTH stages) with RotWord on a key word.
// Define SHIFT_ROWS_INV_EN to add per-beat in_inv selecting InvShiftRows with the key word unrotated.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef SHIFT_ROWS_INV_EN
  input  logic                         in_inv,
`endif
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*NB-1:0]             in_state,
  input  logic [31:0]                  in_kword,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [32*NB-1:0]             out_state,
  output logic [31:0]                  out_kword,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int DATA_W = 32 * NB;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  function automatic int row_shift(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB >= 7) ? 4 : 3;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] shift_rows(input logic [DATA_W-1:0] s, input logic inv);
    logic [DATA_W-1:0] o;
    int src;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + NB - row_shift(r)) % NB : (c + row_shift(r)) % NB;
        o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] k, input logic inv);
    return inv ? k : {k[7:0], k[31:8]};
  endfunction

  logic inv_w;
`ifdef SHIFT_ROWS_INV_EN
  assign inv_w = in_inv;
`else
  assign inv_w = 1'b0;
`endif

  logic [DEPTH-1:0]  vld_q, vld_d, load;
  logic [DATA_W-1:0] state_q [DEPTH];
  logic [DATA_W-1:0] state_d [DEPTH];
  logic [31:0]       kword_q [DEPTH];
  logic [31:0]       kword_d [DEPTH];
  logic [OCC_W-1:0]  occ_cnt;

  // A stage loads when it is empty or its beat moves on; resolved from the output backwards.
  always_comb begin : ready_chain
    logic take;
    take = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      load[k] = !vld_q[k] | take;
      take    = !vld_q[k] | take;
    end
  end

  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < DEPTH; k++) begin
      state_d[k] = state_q[k];
      kword_d[k] = kword_q[k];
    end
    // Stage 0: transform at the input, registers only ever see shifted data
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        state_d[0] = shift_rows(in_state, inv_w);
        kword_d[0] = rot_word(in_kword, inv_w);
      end
    end
    // Later stages: data only moves with a valid beat so idle outputs stay quiet
    for (int k = 1; k < DEPTH; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          state_d[k] = state_q[k-1];
          kword_d[k] = kword_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        state_q[k] <= '0;
        kword_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < DEPTH; k++) begin
        state_q[k] <= state_d[k];
        kword_q[k] <= kword_d[k];
      end
    end
  end

  always_comb begin
    occ_cnt = '0;
    for (int k = 0; k < DEPTH; k++) occ_cnt = occ_cnt + OCC_W'(vld_q[k]);
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[DEPTH-1];
  assign out_state = state_q[DEPTH-1];
  assign out_kword = kword_q[DEPTH-1];
  assign occ       = occ_cnt;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: NB=4/DEPTH=3 instance under a scoreboard, plus an NB=8/DEPTH=1 instance.
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NB=4, DEPTH=3
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_in_inv;
  logic [127:0] a_in_state, a_out_state;
  logic [31:0]  a_in_kword, a_out_kword;
  logic [1:0]   a_occ;

  // Instance B: NB=8, DEPTH=1
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_in_inv;
  logic [255:0] b_in_state, b_out_state;
  logic [31:0]  b_in_kword, b_out_kword;
  logic         b_occ;

  shift_rows_pipe #(.NB(4), .DEPTH(3)) u_a (
    .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_INV_EN
    .in_inv(a_in_inv),
`endif
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(a_in_state), .in_kword(a_in_kword),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_state(a_out_state), .out_kword(a_out_kword),
    .occ(a_occ));

  shift_rows_pipe #(.NB(8), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst),
`ifdef SHIFT_ROWS_INV_EN
    .in_inv(b_in_inv),
`endif
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state), .in_kword(b_in_kword),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_state(b_out_state), .out_kword(b_out_kword),
    .occ(b_occ));

  typedef struct { logic [127:0] st; logic [31:0] kw; } beat_t;
  beat_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int occ_m = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // State viewed as a 4 x nb byte matrix; row r is rotated left by its offset (right when inverse).
  function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input logic inv);
    logic [7:0] m [4][8];
    int off [4];
    int src;
    logic [255:0] o;
    o = '0;
    off = '{0, 1, 2, 3};
    if (nb == 7) off[3] = 4;
    if (nb == 8) begin off[2] = 3; off[3] = 4; end
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[8*(4*c+r) +: 8];
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        o[8*(4*c+r) +: 8] = m[r][src];
      end
    return o;
  endfunction

  function automatic logic [31:0] ref_rot(input logic [31:0] k, input logic inv);
    logic [7:0] kb [4];
    for (int i = 0; i < 4; i++) kb[i] = k[8*i +: 8];
    return inv ? k : {kb[0], kb[3], kb[2], kb[1]};
  endfunction

  function automatic logic [127:0] bytes_from(input logic [7:0] base);
    logic [127:0] v;
    for (int j = 0; j < 16; j++) v[8*j +: 8] = base + 8'(j);
    return v;
  endfunction

  // One clock of instance A, with handshake bookkeeping, scoreboard and hold checks.
  task automatic a_cycle();
    logic in_f, out_f, hold, idle;
    logic [127:0] pst;
    logic [31:0]  pkw;
    logic [255:0] full;
    beat_t b;
    #1;
    in_f  = a_in_valid & a_in_ready;
    out_f = a_out_valid & a_out_ready;
    hold  = a_out_valid & ~a_out_ready;
    idle  = ~a_out_valid;
    pst   = a_out_state;
    pkw   = a_out_kword;
    chk("in_ready_rule", 256'(a_in_ready), 256'((occ_m < 3) || a_out_ready));
    if (out_f) begin
      if (q.size() == 0) chk("spurious_out", 256'(a_out_valid), 256'(0));
      else begin
        b = q.pop_front();
        chk("out_state", 256'(a_out_state), 256'(b.st));
        chk("out_kword", 256'(a_out_kword), 256'(b.kw));
      end
    end
    if (in_f) begin
      full = ref_shift(256'(a_in_state), 4, a_in_inv);
      b.st = full[127:0];
      b.kw = ref_rot(a_in_kword, a_in_inv);
      q.push_back(b);
    end
    @(posedge clk);
    #1;
    occ_m = occ_m + int'(in_f) - int'(out_f);
    chk("occ", 256'(a_occ), 256'(occ_m));
    if (hold) begin
      chk("hold_valid", 256'(a_out_valid), 256'(1));
      chk("hold_state", 256'(a_out_state), 256'(pst));
      chk("hold_kword", 256'(a_out_kword), 256'(pkw));
    end else if (idle && !a_out_valid) begin
      chk("idle_state", 256'(a_out_state), 256'(pst));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] full;
    logic [255:0] bexp;
    logic [1:0]   occ_pk;
    logic [5:0]   ov;
    int cnt;

    rst = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_in_inv = 0; a_in_state = '0; a_in_kword = '0;
    b_in_valid = 0; b_out_ready = 1; b_in_inv = 0; b_in_state = '0; b_in_kword = '0;
    @(posedge clk); #1;
    chk("rst_out_valid", 256'(a_out_valid), 256'(0));
    chk("rst_out_state", 256'(a_out_state), 256'(0));
    chk("rst_out_kword", 256'(a_out_kword), 256'(0));
    chk("rst_occ", 256'(a_occ), 256'(0));
    chk("rst_in_ready", 256'(a_in_ready), 256'(1));
    chk("rst_b_out_valid", 256'(b_out_valid), 256'(0));
    rst = 1'b0;

    // Known AES vector and the 3-cycle latency
    a_in_valid = 1; a_in_state = bytes_from(8'h00); a_in_kword = 32'h0F0E0D0C; a_out_ready = 1;
    a_cycle();
    a_in_valid = 0;
    chk("lat_edge1", 256'(a_out_valid), 256'(0));
    a_cycle();
    chk("lat_edge2", 256'(a_out_valid), 256'(0));
    a_cycle();
    chk("lat_edge3", 256'(a_out_valid), 256'(1));
    chk("vec_state", 256'(a_out_state), 256'(128'h0B06010C07020D08030E09040F0A0500));
    chk("vec_kword", 256'(a_out_kword), 256'(32'h0C0F0E0D));
    a_cycle();

    // Three back-to-back beats emerge on edges 3,4,5
    occ_pk = '0;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = (i < 3);
      a_in_state = bytes_from((i == 0) ? 8'h10 : (i == 1) ? 8'h50 : 8'h70);
      a_in_kword = $urandom;
      a_cycle();
      ov[i] = a_out_valid;
      if (a_occ > occ_pk) occ_pk = a_occ;
    end
    chk("b2b_valid_pattern", 256'(ov), 256'(6'b011100));
    chk("b2b_occ_peak", 256'(occ_pk), 256'(3));

    // Stall with input pending: fills and drops in_ready, then streams at 1/cycle
    a_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1; a_in_state = {$urandom, $urandom, $urandom, $urandom}; a_in_kword = $urandom;
      a_cycle();
    end
    chk("stall_occ", 256'(a_occ), 256'(3));
    chk("stall_in_ready", 256'(a_in_ready), 256'(0));
    a_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      a_cycle();
      chk("stream_valid", 256'(a_out_valid), 256'(1));
      a_in_state = {$urandom, $urandom, $urandom, $urandom}; a_in_kword = $urandom;
    end
    a_in_valid = 0;
    for (int i = 0; i < 4; i++) a_cycle();

`ifdef SHIFT_ROWS_INV_EN
    a_in_valid = 1; a_in_inv = 1;
    a_in_state = 128'h0B06010C07020D08030E09040F0A0500; a_in_kword = 32'h0F0E0D0C;
    a_cycle();
    a_in_valid = 0; a_in_inv = 0;
    a_cycle(); a_cycle();
    chk("inv_state", 256'(a_out_state), 256'(bytes_from(8'h00)));
    chk("inv_kword", 256'(a_out_kword), 256'(32'h0F0E0D0C));
    a_cycle();
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_in_state  = {$urandom, $urandom, $urandom, $urandom};
      a_in_kword  = $urandom;
`ifdef SHIFT_ROWS_INV_EN
      a_in_inv    = $urandom_range(0, 1);
`endif
      a_cycle();
    end
    a_in_valid = 0; a_out_ready = 1; a_in_inv = 0;
    cnt = 0;
    while ((q.size() != 0 || occ_m != 0) && cnt < 20) begin
      a_cycle();
      cnt++;
    end
    chk("drain_queue", 256'(q.size()), 256'(0));
    chk("drain_valid", 256'(a_out_valid), 256'(0));

    // NB=8 instance: row offsets 0,1,3,4
    b_in_valid = 1; b_in_kword = 32'h33221100;
    for (int j = 0; j < 32; j++) b_in_state[8*j +: 8] = 8'(j);
    bexp = ref_shift(b_in_state, 8, 1'b0);
    @(posedge clk); #1;
    b_in_valid = 0;
    chk("nb8_valid", 256'(b_out_valid), 256'(1));
    chk("nb8_byte2", 256'(b_out_state[23:16]), 256'(8'h0E));
    chk("nb8_byte3", 256'(b_out_state[31:24]), 256'(8'h13));
    chk("nb8_state", b_out_state, bexp);
    chk("nb8_kword", 256'(b_out_kword), 256'(32'h00332211));
    for (int i = 0; i < 6; i++) begin
      b_in_valid = 1;
      b_in_state = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_in_kword = $urandom;
`ifdef SHIFT_ROWS_INV_EN
      b_in_inv   = $urandom_range(0, 1);
`endif
      bexp = ref_shift(b_in_state, 8, b_in_inv);
      full = 256'(ref_rot(b_in_kword, b_in_inv));
      @(posedge clk); #1;
      chk("nb8_rand_state", b_out_state, bexp);
      chk("nb8_rand_kword", 256'(b_out_kword), full);
    end
    b_in_valid = 0;

    // Reset with two beats in flight
    a_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1; a_in_state = {$urandom, $urandom, $urandom, $urandom}; a_in_kword = $urandom;
      a_cycle();
    end
    a_in_valid = 0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 256'(a_out_valid), 256'(0));
    chk("midrst_occ", 256'(a_occ), 256'(0));
    q.delete();
    occ_m = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    a_out_ready = 1; a_in_valid = 1;
    a_in_state = bytes_from(8'hAA); a_in_kword = 32'hAAABACAD;
    a_cycle();
    a_in_valid = 0;
    a_cycle(); a_cycle();
    full = ref_shift(256'(bytes_from(8'hAA)), 4, 1'b0);
    chk("post_rst_valid", 256'(a_out_valid), 256'(1));
    chk("post_rst_state", 256'(a_out_state), 256'(full[127:0]));
    a_cycle();
    chk("post_rst_empty", 256'(a_out_valid), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
